// File: rtl/lockout_controller_pkg.sv
// Shared parameters for the safe lock controller: interval timer constants,
// lockout controller defaults and the lockout FSM state encoding.
package lockout_controller_pkg;

    localparam int IT_COUNT_W          = 16;
    localparam int IT_DEFAULT_INTERVAL = 1000;

    localparam int LC_MAX_FAILS_DEF    = 3;
    localparam int LC_MAX_LOCKOUTS_DEF = 4;
    localparam int LC_WD_CYCLES_DEF    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ALARM = 2'd3
    } lc_state_e;

endpackage

// File: rtl/lockout_watchdog.sv
// Loadable down-counter guarding the WAIT state; expired flags a count of zero.
module lockout_watchdog #(
    parameter int WD_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int W = $clog2(WD_CYCLES);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = W'(WD_CYCLES - 1);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/lockout_controller.sv
// Failed-attempt lockout FSM driving the interval timer start/done handshake.
// Build option LOCKOUT_ESCALATION_EN adds the lockout counter and sticky ALARM.
module lockout_controller
    import lockout_controller_pkg::*;
#(
    parameter int MAX_FAILS    = LC_MAX_FAILS_DEF,
    parameter int MAX_LOCKOUTS = LC_MAX_LOCKOUTS_DEF,
    parameter int WD_CYCLES    = LC_WD_CYCLES_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           attempt_valid,
    input  logic                           attempt_ok,
    input  logic                           timer_done,
    output logic                           timer_start,
    output logic                           lockout,
    output logic                           unlock,
    output logic                           alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);

    lc_state_e     state_q, state_d;
    logic [FW-1:0] fail_q, fail_d;
    logic          unlock_q, unlock_d;
    logic          wd_clear, wd_load, wd_dec, wd_expired;

`ifdef LOCKOUT_ESCALATION_EN
    localparam int LW = $clog2(MAX_LOCKOUTS + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCKOUTS - 1);
    logic [LW-1:0] lock_q, lock_d;
`else
    // Keeps the escalation parameter referenced in the plain build.
    localparam int UNUSED_MAX_LOCKOUTS = MAX_LOCKOUTS;
`endif

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        unlock_d = 1'b0;
        wd_clear = 1'b0;
        wd_load  = 1'b0;
        wd_dec   = 1'b0;
`ifdef LOCKOUT_ESCALATION_EN
        lock_d   = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                wd_clear = 1'b1;
                if (attempt_valid) begin
                    if (attempt_ok) begin
                        unlock_d = 1'b1;
                        fail_d   = '0;
`ifdef LOCKOUT_ESCALATION_EN
                        lock_d   = '0;
`endif
                    end else if (fail_q == FAIL_LAST) begin
                        fail_d  = fail_q + 1'b1;
                        state_d = ST_START;
                    end else if (fail_q < FAIL_LAST) begin
                        fail_d = fail_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                wd_load = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_dec = 1'b1;
                // A done arriving on the expiry cycle still completes the lockout.
                if (timer_done) begin
                    fail_d  = '0;
                    state_d = ST_IDLE;
`ifdef LOCKOUT_ESCALATION_EN
                    lock_d = lock_q + 1'b1;
                    if (lock_q == LOCK_LAST) begin
                        state_d = ST_ALARM;
                    end
`endif
                end else if (wd_expired) begin
                    state_d = ST_START;
                end
            end
`ifdef LOCKOUT_ESCALATION_EN
            ST_ALARM: begin
                wd_clear = 1'b1;
            end
`endif
            default: begin
                wd_clear = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fail_q   <= '0;
            unlock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            unlock_q <= unlock_d;
        end
    end

`ifdef LOCKOUT_ESCALATION_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign alarm = (state_q == ST_ALARM);
`else
    assign alarm = 1'b0;
`endif

    lockout_watchdog #(
        .WD_CYCLES (WD_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .load    (wd_load),
        .dec     (wd_dec),
        .expired (wd_expired)
    );

    assign timer_start = (state_q == ST_START);
    assign lockout     = (state_q != ST_IDLE);
    assign unlock      = unlock_q;
    assign fail_count  = fail_q;

endmodule
